// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: pad sync, ps2_clk deglitch, 11-bit frame deserialiser.
// Optional frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_rx_frame #(
   parameter int CLK_HZ     = 100_000_000,
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT_US = 2000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_err,
   output logic       busy
);

   localparam int         TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
   localparam logic [7:0] FLEN_M1     = 8'(FILTER_LEN - 1);

   if (FILTER_LEN < 2 || FILTER_LEN > 255 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("ps2_rx_frame: FILTER_LEN must be 2..255 and TIMEOUT_CYC at least 1");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   // Front end: two-flop synchronisers, clock filter and fall pulse
   logic [1:0] clk_s;
   logic [1:0] data_s;
   logic       filt_clk;
   logic [7:0] filt_cnt;
   logic       fall;
   logic       bit_in;

   assign bit_in = data_s[1];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         clk_s    <= 2'b11;
         data_s   <= 2'b11;
         filt_clk <= 1'b1;
         filt_cnt <= 8'd0;
         fall     <= 1'b0;
      end else begin
         clk_s  <= {clk_s[0], ps2_clk};
         data_s <= {data_s[0], ps2_data};
         fall   <= 1'b0;
         if (clk_s[1] != filt_clk) begin
            if (filt_cnt == FLEN_M1) begin
               filt_clk <= ~filt_clk;
               filt_cnt <= 8'd0;
               // fall lines up with the cycle in which filt_clk reads 0
               fall     <= filt_clk;
            end else begin
               filt_cnt <= filt_cnt + 8'd1;
            end
         end else begin
            filt_cnt <= 8'd0;
         end
      end
   end

   // Frame state machine
   state_t     state, state_nx;
   logic [7:0] sr, sr_nx;
   logic [2:0] cnt, cnt_nx;
   logic       acc, acc_nx;
   logic [7:0] rx_data_nx;
   logic       rx_valid_nx;
   logic       rx_err_nx;
   logic       timeout_hit;

`ifdef PS2_RX_TIMEOUT_EN
   localparam int                TO_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0]   TO_MAX = TO_W'(TIMEOUT_CYC);
   logic [TO_W-1:0] to_cnt;

   always_ff @(posedge clk) begin
      if (!rstn || fall || state == IDLE) begin
         to_cnt <= '0;
      end else if (to_cnt != TO_MAX) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign timeout_hit = (to_cnt == TO_MAX) && (state != IDLE);
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state    <= IDLE;
         sr       <= 8'h00;
         cnt      <= 3'd0;
         acc      <= 1'b0;
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         sr       <= sr_nx;
         cnt      <= cnt_nx;
         acc      <= acc_nx;
         rx_data  <= rx_data_nx;
         rx_valid <= rx_valid_nx;
         rx_err   <= rx_err_nx;
         busy     <= (state_nx != IDLE);
      end
   end

   always_comb begin
      state_nx    = state;
      sr_nx       = sr;
      cnt_nx      = cnt;
      acc_nx      = acc;
      rx_data_nx  = rx_data;
      rx_valid_nx = 1'b0;
      rx_err_nx   = 1'b0;
      if (fall) begin
         case (state)
            IDLE: begin
               if (!bit_in) begin
                  state_nx = DATA;
                  cnt_nx   = 3'd0;
                  acc_nx   = 1'b0;
               end
            end
            DATA: begin
               sr_nx  = {bit_in, sr[7:1]};
               acc_nx = acc ^ bit_in;
               cnt_nx = cnt + 3'd1;
               if (cnt == 3'd7) begin
                  state_nx = PARITY;
               end
            end
            PARITY: begin
               acc_nx   = acc ^ bit_in;
               state_nx = STOP;
            end
            STOP: begin
               if (bit_in && acc) begin
                  rx_data_nx  = sr;
                  rx_valid_nx = 1'b1;
               end else begin
                  rx_err_nx = 1'b1;
               end
               state_nx = IDLE;
            end
            default: state_nx = IDLE;
         endcase
      end else if (timeout_hit) begin
         // a fall in the same cycle takes priority over the watchdog
         state_nx  = IDLE;
         rx_err_nx = 1'b1;
      end
   end

endmodule

// File: tb/tb_ps2_rx_frame.sv
// Bench for ps2_rx_frame: directed and randomized PS/2 frames checked against a frame-level model.
// Follows the PS2_RX_TIMEOUT_EN define of the build for the truncated-frame step.
module tb_ps2_rx_frame;

   localparam int CLK_HZ      = 1_000_000;
   localparam int FILTER_LEN  = 8;
   localparam int TIMEOUT_US  = 200;
   localparam int TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;

   logic       clk      = 1'b0;
   logic       rstn     = 1'b0;
   logic       ps2_clk  = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic       busy;

   always #5 clk = ~clk;

   ps2_rx_frame #(
      .CLK_HZ     (CLK_HZ),
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT_US (TIMEOUT_US)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_err   (rx_err),
      .busy     (busy)
   );

   int         vectors     = 0;
   int         miscompares = 0;
   int         v_cnt       = 0;
   int         e_cnt       = 0;
   int         both_cnt    = 0;
   int         half        = 40;
   logic       mid_busy    = 1'b0;
   logic [7:0] exp_last    = 8'h00;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   // Strobe monitor: records every byte delivered and every rejection
   always @(negedge clk) begin
      if (rx_valid) begin
         v_cnt++;
         got_q.push_back(rx_data);
      end
      if (rx_err) e_cnt++;
      if (rx_valid && rx_err) both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One PS/2 bit: data settles during the high half, device pulls clock low for the other half
   task automatic send_bit(input logic b);
      ps2_data = b;
      repeat (half) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (half) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         send_bit(bits[i]);
         if (i == 0) mid_busy = busy;
      end
   endtask

   function automatic logic frame_good(input logic [7:0] d, input logic par, input logic stop);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      ones += int'(par);
      return (stop == 1'b1) && (ones % 2 == 1);
   endfunction

   function automatic logic odd_par(input logic [7:0] d);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return (ones % 2 == 0);
   endfunction

   task automatic run_frame(input string tag, input logic [7:0] d, input logic par, input logic stop);
      int         v0, e0;
      logic       good;
      logic [7:0] got;
      v0   = v_cnt;
      e0   = e_cnt;
      good = frame_good(d, par, stop);
      if (good) begin
         exp_q.push_back(d);
         exp_last = d;
      end
      send_bits({stop, par, d, 1'b0}, 11);
      chk({tag, " valid_count"}, v_cnt - v0, good ? 1 : 0);
      chk({tag, " err_count"}, e_cnt - e0, good ? 0 : 1);
      if (good) begin
         got = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
         chk({tag, " byte"}, got, exp_q.pop_front());
      end
      got_q.delete();
      chk({tag, " rx_data"}, rx_data, exp_last);
      chk({tag, " busy_mid"}, mid_busy, 1'b1);
      chk({tag, " busy_end"}, busy, 1'b0);
   endtask

   initial begin
      int         v0, e0;
      logic [7:0] d;
      int         kind;

      // Reset state
      rstn = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset rx_data", rx_data, 8'h00);
      chk("reset rx_valid", rx_valid, 1'b0);
      chk("reset rx_err", rx_err, 1'b0);
      chk("reset busy", busy, 1'b0);
      rstn = 1'b1;
      repeat (5) @(negedge clk);

      // 0x5A at 80 cycles per bit
      half = 40;
      run_frame("f5a", 8'h5A, 1'b1, 1'b1);

      // Mouse packet back to back
      run_frame("pkt0", 8'h08, 1'b0, 1'b1);
      run_frame("pkt1", 8'h01, 1'b0, 1'b1);
      run_frame("pkt2", 8'hFF, 1'b1, 1'b1);

      // Parity error keeps the previous byte
      run_frame("bad_par", 8'h5A, 1'b0, 1'b1);

      // Clock glitches shorter than the filter window
      v0 = v_cnt;
      e0 = e_cnt;
      for (int g = FILTER_LEN - 2; g <= FILTER_LEN - 1; g++) begin
         ps2_clk = 1'b0;
         repeat (g) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (20) @(negedge clk);
         chk("glitch busy", busy, 1'b0);
      end
      chk("glitch strobes", (v_cnt - v0) + (e_cnt - e0), 0);

      // Randomized frames, some with corrupted parity or stop bit
      for (int n = 0; n < 10; n++) begin
         half = $urandom_range(16, 40);
         d    = 8'($urandom_range(0, 255));
         kind = $urandom_range(0, 3);
         case (kind)
            2:       run_frame("rnd_badpar", d, ~odd_par(d), 1'b1);
            3:       run_frame("rnd_badstop", d, odd_par(d), 1'b0);
            default: run_frame("rnd_good", d, odd_par(d), 1'b1);
         endcase
      end
      half = 40;

      // Truncated frame: start plus four data bits, then the clock stays high
      v0 = v_cnt;
      e0 = e_cnt;
      send_bits({2'b11, 8'hC3, 1'b0}, 5);
      repeat (TIMEOUT_CYC + 10) @(negedge clk);
`ifdef PS2_RX_TIMEOUT_EN
      chk("timeout err", e_cnt - e0, 1);
      chk("timeout valid", v_cnt - v0, 0);
      chk("timeout busy", busy, 1'b0);
      ps2_data = 1'b1;
      repeat (5) @(negedge clk);
      run_frame("after_to", 8'hA5, odd_par(8'hA5), 1'b1);
`else
      chk("stall busy", busy, 1'b1);
      chk("stall strobes", (v_cnt - v0) + (e_cnt - e0), 0);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      exp_last = 8'h00;
      chk("stall reset busy", busy, 1'b0);
      chk("stall reset rx_data", rx_data, 8'h00);
      ps2_data = 1'b1;
      repeat (5) @(negedge clk);
`endif

      // Reset in the middle of a frame
      v0 = v_cnt;
      e0 = e_cnt;
      send_bits({2'b11, 8'h3C, 1'b0}, 7);
      chk("mid busy before reset", busy, 1'b1);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      exp_last = 8'h00;
      chk("mid reset busy", busy, 1'b0);
      chk("mid reset rx_data", rx_data, 8'h00);
      chk("mid reset strobes", (v_cnt - v0) + (e_cnt - e0), 0);
      ps2_data = 1'b1;
      repeat (5) @(negedge clk);
      run_frame("f3c", 8'h3C, odd_par(8'h3C), 1'b1);

      repeat (10) @(negedge clk);
      chk("valid_and_err_overlap", both_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Overall time bound in case a DUT event never arrives
   initial begin
      #5_000_000;
      miscompares++;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "time limit");
   end

endmodule
